// File: rtl/nway_dcache.sv
// rtl/nway_dcache.sv - N-way set-associative write-back data cache with round-robin replacement
module nway_dcache #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_BYTES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic                      i_mem_rw,
    input  logic [31:0]               i_addr,
    input  logic [31:0]               i_data_w,
    output logic                      o_ack,
    output logic [31:0]               o_data,
    output logic                      o_stall,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [31:0]               o_mem_addr,
    output logic [8*LINE_BYTES-1:0]   o_mem_wdata,
    input  logic                      i_mem_ack,
    input  logic [8*LINE_BYTES-1:0]   i_mem_rdata,
    output logic [31:0]               o_hit_count,
    output logic [31:0]               o_miss_count
);
    localparam int LINE_BITS = 8 * LINE_BYTES;
    localparam int OFF_W     = $clog2(LINE_BYTES);
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = 32 - OFF_W - IDX_W;
    localparam int WORDS     = LINE_BYTES / 4;
    localparam int WSEL_W    = OFF_W - 2;
    localparam int PTR_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL} state_e;

    state_e                 state_q;
    logic [WAYS-1:0]        valid_q [SETS];
    logic [WAYS-1:0]        dirty_q [SETS];
    logic [PTR_W-1:0]       ptr_q   [SETS];
    logic [TAG_W-1:0]       tag_arr_q  [SETS][WAYS];
    logic [LINE_BITS-1:0]   data_arr_q [SETS][WAYS];

    logic [TAG_W-1:0]       miss_tag_q;
    logic [IDX_W-1:0]       miss_idx_q;
    logic [PTR_W-1:0]       victim_q;
    logic                   victim_inv_q;
    logic                   mem_req_q, mem_we_q;
    logic [31:0]            mem_addr_q;
    logic [LINE_BITS-1:0]   mem_wdata_q;
    logic [31:0]            hit_cnt_q, miss_cnt_q;

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [WSEL_W-1:0]      req_wsel;
    logic                   unused_addr;

    assign req_tag     = i_addr[31 -: TAG_W];
    assign req_idx     = i_addr[OFF_W +: IDX_W];
    assign req_wsel    = i_addr[OFF_W-1:2];
    assign unused_addr = ^i_addr[1:0];

    logic                   hit;
    logic [PTR_W-1:0]       hit_way;
    logic [LINE_BITS-1:0]   hit_line;
    logic [PTR_W-1:0]       vic_way;
    logic                   vic_inv;
    logic                   vic_dirty;
    logic [TAG_W-1:0]       vic_tag;
    logic [LINE_BITS-1:0]   vic_line;

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_arr_q[req_idx][w] == req_tag) begin
                hit      = 1'b1;
                hit_way  = PTR_W'(w);
                hit_line = data_arr_q[req_idx][w];
            end
        end
    end

    // Lowest-index invalid way wins; otherwise fall back to the set's round-robin pointer.
    always_comb begin
        vic_way   = ptr_q[req_idx];
        vic_inv   = 1'b0;
        vic_dirty = 1'b0;
        vic_tag   = '0;
        vic_line  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                vic_way = PTR_W'(w);
                vic_inv = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (vic_way == PTR_W'(w)) begin
                vic_dirty = !vic_inv && dirty_q[req_idx][w];
                vic_tag   = tag_arr_q[req_idx][w];
                vic_line  = data_arr_q[req_idx][w];
            end
        end
    end

    always_comb begin
        o_data = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (req_wsel == WSEL_W'(k)) o_data = hit_line[32*k +: 32];
        end
    end

    assign o_ack        = (state_q == S_IDLE) && i_req && hit;
    assign o_stall      = i_req && !o_ack;
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_hit_count  = hit_cnt_q;
    assign o_miss_count = miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            victim_q     <= '0;
            victim_inv_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_req && hit) begin
                        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
                        if (i_mem_rw) begin
                            for (int w = 0; w < WAYS; w++)
                                if (hit_way == PTR_W'(w)) dirty_q[req_idx][w] <= 1'b1;
                        end
                    end else if (i_req) begin
                        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
                        miss_tag_q   <= req_tag;
                        miss_idx_q   <= req_idx;
                        victim_q     <= vic_way;
                        victim_inv_q <= vic_inv;
                        mem_req_q    <= 1'b1;
                        if (vic_dirty) begin
                            state_q     <= S_EVICT;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {vic_tag, req_idx, {OFF_W{1'b0}}};
                            mem_wdata_q <= vic_line;
                        end else begin
                            state_q    <= S_FILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                S_EVICT: begin
                    if (i_mem_ack) begin
                        state_q    <= S_FILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                    end
                end
                S_FILL: begin
                    if (i_mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        for (int w = 0; w < WAYS; w++) begin
                            if (victim_q == PTR_W'(w)) begin
                                valid_q[miss_idx_q][w] <= 1'b1;
                                dirty_q[miss_idx_q][w] <= 1'b0;
                            end
                        end
                        // Only a replacement of a live line moves the round-robin pointer.
                        if (WAYS > 1 && !victim_inv_q)
                            ptr_q[miss_idx_q] <= ptr_q[miss_idx_q] + PTR_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_IDLE && i_req && hit && i_mem_rw) begin
                for (int w = 0; w < WAYS; w++)
                    for (int k = 0; k < WORDS; k++)
                        if (hit_way == PTR_W'(w) && req_wsel == WSEL_W'(k))
                            data_arr_q[req_idx][w][32*k +: 32] <= i_data_w;
            end else if (state_q == S_FILL && i_mem_ack) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (victim_q == PTR_W'(w)) begin
                        data_arr_q[miss_idx_q][w] <= i_mem_rdata;
                        tag_arr_q[miss_idx_q][w]  <= miss_tag_q;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nway_dcache.sv
// tb/tb_nway_dcache.sv - directed bench for nway_dcache (2-way default plus a direct-mapped build)
module tb_nway_dcache;
    logic clk, rst;
    logic         a_req, a_rw, a_ack, a_stall, a_mem_req, a_mem_we, a_mem_ack;
    logic [31:0]  a_addr, a_wd, a_data, a_mem_addr, a_hits, a_misses;
    logic [511:0] a_wdata, a_rdata;
    logic         b_req, b_rw, b_ack, b_stall, b_mem_req, b_mem_we, b_mem_ack;
    logic [31:0]  b_addr, b_wd, b_data, b_mem_addr, b_hits, b_misses;
    logic [511:0] b_wdata, b_rdata;
    int errors = 0;
    int checks = 0;

    nway_dcache #(.WAYS(2), .SETS(256), .LINE_BYTES(64)) dut_a (
        .clk(clk), .rst(rst), .i_req(a_req), .i_mem_rw(a_rw), .i_addr(a_addr),
        .i_data_w(a_wd), .o_ack(a_ack), .o_data(a_data), .o_stall(a_stall),
        .o_mem_req(a_mem_req), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_wdata), .i_mem_ack(a_mem_ack), .i_mem_rdata(a_rdata),
        .o_hit_count(a_hits), .o_miss_count(a_misses));

    nway_dcache #(.WAYS(1), .SETS(256), .LINE_BYTES(64)) dut_b (
        .clk(clk), .rst(rst), .i_req(b_req), .i_mem_rw(b_rw), .i_addr(b_addr),
        .i_data_w(b_wd), .o_ack(b_ack), .o_data(b_data), .o_stall(b_stall),
        .o_mem_req(b_mem_req), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_wdata), .i_mem_ack(b_mem_ack), .i_mem_rdata(b_rdata),
        .o_hit_count(b_hits), .o_miss_count(b_misses));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word k of the line is seed+k, except word 1 which carries w1.
    function automatic logic [511:0] mk_line(input logic [31:0] w1, input logic [31:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = seed + 32'(k);
        l[63:32] = w1;
        return l;
    endfunction

    initial begin
        logic [31:0] baddr;
        rst = 1'b1;
        a_req = 0; a_rw = 0; a_addr = 0; a_wd = 0; a_mem_ack = 0; a_rdata = '0;
        b_req = 0; b_rw = 0; b_addr = 0; b_wd = 0; b_mem_ack = 0; b_rdata = '0;
        tick(); tick();
        check("rst_ack", a_ack, 0);
        check("rst_mem_req", a_mem_req, 0);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_hits", a_hits, 0);
        check("rst_misses", a_misses, 0);
        check("rst_b_mem_req", b_mem_req, 0);
        rst = 1'b0;

        // Cold read miss then fill
        a_req = 1; a_rw = 0; a_addr = 32'h0000_1044; #1;
        check("cold_ack", a_ack, 0);
        check("cold_stall", a_stall, 1);
        tick();
        check("cold_mem_req", a_mem_req, 1);
        check("cold_mem_we", a_mem_we, 0);
        check("cold_mem_addr", a_mem_addr, 32'h0000_1040);
        check("cold_misses", a_misses, 1);
        check("cold_fill_ack", a_ack, 0);
        a_mem_ack = 1; a_rdata = mk_line(32'hDEAD_BEEF, 32'h100);
        tick();
        a_mem_ack = 0; #1;
        check("cold_hit_ack", a_ack, 1);
        check("cold_data", a_data, 32'hDEAD_BEEF);
        check("cold_idle_mem_req", a_mem_req, 0);
        tick();
        a_req = 0; #1;
        check("cold_hits", a_hits, 1);
        check("cold_misses2", a_misses, 1);

        // Write hit then read back
        a_req = 1; a_rw = 1; a_wd = 32'h1234_5678; #1;
        check("wr_ack", a_ack, 1);
        check("wr_mem_req", a_mem_req, 0);
        tick();
        a_rw = 0; #1;
        check("rd_ack", a_ack, 1);
        check("rd_data", a_data, 32'h1234_5678);
        tick();
        a_req = 0; #1;
        check("wr_hits", a_hits, 3);

        // Same index, invalid way 1 fills first
        a_req = 1; a_addr = 32'h0000_5040; #1;
        tick();
        check("w1_mem_we", a_mem_we, 0);
        check("w1_mem_addr", a_mem_addr, 32'h0000_5040);
        a_mem_ack = 1; a_rdata = mk_line(32'hAAAA_0001, 32'h200);
        tick();
        a_mem_ack = 0; #1;
        check("w1_ack", a_ack, 1);
        check("w1_data", a_data, 32'h200);
        tick();
        a_req = 0; #1;

        // Both ways valid: way 0 is dirty and evicted
        a_req = 1; a_addr = 32'h0000_9040; #1;
        tick();
        check("ev_mem_req", a_mem_req, 1);
        check("ev_mem_we", a_mem_we, 1);
        check("ev_mem_addr", a_mem_addr, 32'h0000_1040);
        check("ev_word1", a_wdata[63:32], 32'h1234_5678);
        check("ev_word0", a_wdata[31:0], 32'h100);
        check("ev_misses", a_misses, 3);
        check("ev_ack", a_ack, 0);
        a_mem_ack = 1;
        tick();
        a_mem_ack = 0; #1;
        check("ev_fill_we", a_mem_we, 0);
        check("ev_fill_addr", a_mem_addr, 32'h0000_9040);

        // Slow memory: fill held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            check("slow_mem_req", a_mem_req, 1);
            check("slow_mem_addr", a_mem_addr, 32'h0000_9040);
            check("slow_ack", a_ack, 0);
            check("slow_stall", a_stall, 1);
            tick();
        end
        a_mem_ack = 1; a_rdata = mk_line(32'hBBBB_0001, 32'h300);
        tick();
        a_mem_ack = 0; #1;
        check("slow_hit_ack", a_ack, 1);
        check("slow_data", a_data, 32'h300);
        tick();
        a_req = 0; #1;
        check("slow_hits", a_hits, 5);
        check("slow_misses", a_misses, 3);

        // Reset mid-fill, then a late memory ack in IDLE
        a_req = 1; a_addr = 32'h0000_1044; #1;
        tick();
        check("rf_mem_req", a_mem_req, 1);
        check("rf_mem_we", a_mem_we, 0);
        check("rf_mem_addr", a_mem_addr, 32'h0000_1040);
        check("rf_misses", a_misses, 4);
        tick();
        rst = 1; #1;
        check("rf_rst_mem_req", a_mem_req, 0);
        check("rf_rst_misses", a_misses, 0);
        check("rf_rst_hits", a_hits, 0);
        a_req = 0;
        tick();
        rst = 0; a_mem_ack = 1;
        tick();
        a_mem_ack = 0; #1;
        check("late_ack_mem_req", a_mem_req, 0);
        check("late_ack_misses", a_misses, 0);
        a_req = 1; a_addr = 32'h0000_1044; #1;
        check("post_rst_ack", a_ack, 0);
        tick();
        check("post_rst_mem_req", a_mem_req, 1);
        check("post_rst_mem_addr", a_mem_addr, 32'h0000_1040);
        check("post_rst_misses", a_misses, 1);
        a_mem_ack = 1; a_rdata = mk_line(32'hCAFE_F00D, 32'h400);
        tick();
        a_mem_ack = 0; #1;
        check("post_rst_data", a_data, 32'hCAFE_F00D);
        tick();
        a_req = 0; #1;

        // Direct-mapped build: alternating conflicting lines always miss, never evict
        for (int i = 0; i < 4; i++) begin
            baddr = (i % 2 == 0) ? 32'h0000_1040 : 32'h0000_5040;
            b_req = 1; b_addr = baddr; #1;
            check("dm_miss_ack", b_ack, 0);
            tick();
            check("dm_mem_req", b_mem_req, 1);
            check("dm_mem_we", b_mem_we, 0);
            check("dm_mem_addr", b_mem_addr, baddr);
            b_mem_ack = 1; b_rdata = mk_line(32'h0, 32'(i) << 8);
            tick();
            b_mem_ack = 0; #1;
            check("dm_ack", b_ack, 1);
            check("dm_data", b_data, 32'(i) << 8);
            tick();
            b_req = 0; #1;
        end
        check("dm_misses", b_misses, 4);
        check("dm_hits", b_hits, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
